// File: rtl/wb_regfile_sb.sv
// Register file with per-register pending-write scoreboard for the ID stage.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data and release stalls one cycle earlier.
module wb_regfile_sb #(
    parameter int D_SIZE        = 32,
    parameter int ADDR_LINE_REG = 5,
    parameter int NUM_REG       = 32,
    parameter int CNT_W         = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_en,
    input  logic [ADDR_LINE_REG-1:0] wb_addr,
    input  logic [D_SIZE-1:0]        wb_data,
    input  logic [ADDR_LINE_REG-1:0] rs_addr,
    input  logic [ADDR_LINE_REG-1:0] rt_addr,
    input  logic                     rs_used,
    input  logic                     rt_used,
    output logic [D_SIZE-1:0]        rs_data,
    output logic [D_SIZE-1:0]        rt_data,
    input  logic                     rsv_en,
    input  logic [ADDR_LINE_REG-1:0] rsv_addr,
    output logic                     stall,
    output logic                     wb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [D_SIZE-1:0] regs_q [NUM_REG];
    logic [D_SIZE-1:0] regs_d [NUM_REG];
    logic [CNT_W-1:0]  cnt_q  [NUM_REG];
    logic [CNT_W-1:0]  cnt_d  [NUM_REG];
    logic              wb_err_q;
    logic              wb_err_d;
    logic              rs_haz;
    logic              rt_haz;
    logic              full;

    // R0 and out-of-range addresses are inert: never read, written, reserved or stalled on.
    function automatic logic addr_ok(input logic [ADDR_LINE_REG-1:0] a);
        return (a != {ADDR_LINE_REG{1'b0}}) && (32'(a) < 32'(NUM_REG));
    endfunction

    function automatic logic wb_hit(input logic [ADDR_LINE_REG-1:0] a);
        return wb_en && (wb_addr == a);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_at(input logic [ADDR_LINE_REG-1:0] a);
        if (addr_ok(a)) begin
            return cnt_q[a];
        end else begin
            return {CNT_W{1'b0}};
        end
    endfunction

    function automatic logic src_haz(input logic [ADDR_LINE_REG-1:0] a, input logic used);
        logic [CNT_W-1:0] eff;
`ifdef REGFILE_BYPASS_EN
        eff = cnt_at(a) - CNT_W'(wb_hit(a) && (cnt_at(a) != {CNT_W{1'b0}}));
`else
        eff = cnt_at(a);
`endif
        return used && addr_ok(a) && (eff != {CNT_W{1'b0}});
    endfunction

    // Hazard detection: source operands still pending, or destination counter saturated.
    always_comb begin
        rs_haz = src_haz(rs_addr, rs_used);
        rt_haz = src_haz(rt_addr, rt_used);
        full   = rsv_en && addr_ok(rsv_addr) && (cnt_at(rsv_addr) == CNT_MAX) && !wb_hit(rsv_addr);
        stall  = rs_haz || rt_haz || full;
    end

    // Read ports.
    always_comb begin
        rs_data = {D_SIZE{1'b0}};
        rt_data = {D_SIZE{1'b0}};
        if (addr_ok(rs_addr)) begin
`ifdef REGFILE_BYPASS_EN
            rs_data = wb_hit(rs_addr) ? wb_data : regs_q[rs_addr];
`else
            rs_data = regs_q[rs_addr];
`endif
        end else begin
            rs_data = {D_SIZE{1'b0}};
        end
        if (addr_ok(rt_addr)) begin
`ifdef REGFILE_BYPASS_EN
            rt_data = wb_hit(rt_addr) ? wb_data : regs_q[rt_addr];
`else
            rt_data = regs_q[rt_addr];
`endif
        end else begin
            rt_data = {D_SIZE{1'b0}};
        end
    end

    // Next-state: commit write-back, track sticky error, update pending counters.
    always_comb begin
        regs_d   = regs_q;
        cnt_d    = cnt_q;
        wb_err_d = wb_err_q;
        if (wb_en && addr_ok(wb_addr)) begin
            regs_d[wb_addr] = wb_data;
            if (cnt_q[wb_addr] == {CNT_W{1'b0}}) begin
                wb_err_d = 1'b1;
            end else begin
                wb_err_d = wb_err_q;
            end
        end else begin
            wb_err_d = wb_err_q;
        end
        for (int r = 1; r < NUM_REG; r++) begin
            logic inc;
            logic dec;
            inc = rsv_en && (rsv_addr == ADDR_LINE_REG'(r)) && !stall;
            dec = wb_en && (wb_addr == ADDR_LINE_REG'(r)) && (cnt_q[r] != {CNT_W{1'b0}});
            case ({inc, dec})
                2'b10:   cnt_d[r] = cnt_q[r] + CNT_W'(1);
                2'b01:   cnt_d[r] = cnt_q[r] - CNT_W'(1);
                default: cnt_d[r] = cnt_q[r];
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NUM_REG; r++) begin
                regs_q[r] <= {D_SIZE{1'b0}};
                cnt_q[r]  <= {CNT_W{1'b0}};
            end
            wb_err_q <= 1'b0;
        end else begin
            regs_q   <= regs_d;
            cnt_q    <= cnt_d;
            wb_err_q <= wb_err_d;
        end
    end

    assign wb_err = wb_err_q;

endmodule

// File: tb/tb_wb_regfile_sb.sv
// Self-checking bench for wb_regfile_sb: directed scenarios then random traffic against an array model.
module tb_wb_regfile_sb;

    localparam int NUM  = 32;
    localparam int MAXC = 3;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic        rs_used;
    logic        rt_used;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rsv_en;
    logic [4:0]  rsv_addr;
    logic        stall;
    logic        wb_err;

    wb_regfile_sb dut (
        .clk(clk), .reset(reset),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_used(rs_used), .rt_used(rt_used),
        .rs_data(rs_data), .rt_data(rt_data),
        .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .stall(stall), .wb_err(wb_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_reg [NUM];
    int          m_cnt [NUM];
    bit          m_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM; i++) begin
            m_reg[i] = 32'd0;
            m_cnt[i] = 0;
        end
        m_err = 1'b0;
    endtask

    function automatic int eff_cnt(input int a);
        if (BYP && wb_en && int'(wb_addr) == a && m_cnt[a] != 0) return m_cnt[a] - 1;
        return m_cnt[a];
    endfunction

    function automatic bit exp_stall();
        bit h;
        int ra = int'(rs_addr);
        int ta = int'(rt_addr);
        int va = int'(rsv_addr);
        h = 1'b0;
        if (rs_used && ra != 0 && eff_cnt(ra) != 0) h = 1'b1;
        if (rt_used && ta != 0 && eff_cnt(ta) != 0) h = 1'b1;
        if (rsv_en && va != 0 && m_cnt[va] == MAXC && !(wb_en && wb_addr == rsv_addr)) h = 1'b1;
        return h;
    endfunction

    function automatic logic [31:0] exp_data(input int a);
        if (a == 0) return 32'd0;
        if (BYP && wb_en && int'(wb_addr) == a) return wb_data;
        return m_reg[a];
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, "_rs_data"}, rs_data, exp_data(int'(rs_addr)));
        check_eq({tag, "_rt_data"}, rt_data, exp_data(int'(rt_addr)));
        check_eq({tag, "_stall"},   {31'd0, stall},  {31'd0, exp_stall()});
        check_eq({tag, "_wb_err"},  {31'd0, wb_err}, {31'd0, m_err});
    endtask

    // One clock cycle: drive after negedge, check outputs, advance model on the rising edge.
    task automatic cyc(input string tag, input bit we, input int wa, input logic [31:0] wd,
                       input int ra, input int ta, input bit ru, input bit tu,
                       input bit re, input int va);
        bit st;
        int w;
        int v;
        wb_en = we;  wb_addr = wa[4:0];  wb_data = wd;
        rs_addr = ra[4:0];  rt_addr = ta[4:0];  rs_used = ru;  rt_used = tu;
        rsv_en = re;  rsv_addr = va[4:0];
        #1;
        check_outputs(tag);
        st = exp_stall();
        @(posedge clk);
        w = int'(wb_addr);
        v = int'(rsv_addr);
        if (wb_en && w != 0) begin
            if (m_cnt[w] == 0) m_err = 1'b1;
            else m_cnt[w] = m_cnt[w] - 1;
            m_reg[w] = wb_data;
        end
        if (rsv_en && !st && v != 0) m_cnt[v] = m_cnt[v] + 1;
        @(negedge clk);
    endtask

    initial begin
        int pend [$];
        reset = 1'b0;
        wb_en = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        rs_addr = 5'd0; rt_addr = 5'd0; rs_used = 1'b0; rt_used = 1'b0;
        rsv_en = 1'b0; rsv_addr = 5'd0;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int r = 0; r < NUM; r++) cyc("rst_read", 1'b0, 0, 32'd0, r, NUM - 1 - r, 1'b1, 1'b1, 1'b0, 0);

        cyc("r0_write", 1'b1, 0, 32'hFFFF_FFFF, 0, 0, 1'b1, 1'b1, 1'b0, 0);
        cyc("r0_read",  1'b0, 0, 32'd0, 0, 0, 1'b1, 1'b1, 1'b0, 0);

        // RAW on R3 resolved by its write-back.
        cyc("r3_rsv",   1'b0, 0, 32'd0, 0, 0, 1'b0, 1'b0, 1'b1, 3);
        cyc("r3_wait",  1'b0, 0, 32'd0, 3, 0, 1'b1, 1'b0, 1'b0, 0);
        cyc("r3_wait2", 1'b0, 0, 32'd0, 3, 0, 1'b1, 1'b0, 1'b0, 0);
        cyc("r3_wb",    1'b1, 3, 32'h0000_00A5, 3, 0, 1'b1, 1'b0, 1'b0, 0);
        cyc("r3_after", 1'b0, 0, 32'd0, 3, 0, 1'b1, 1'b0, 1'b0, 0);

        // Saturate R7, then a write-back in the same cycle lets the fourth reservation through.
        for (int k = 0; k < 3; k++) cyc("r7_rsv", 1'b0, 0, 32'd0, 0, 7, 1'b0, 1'b0, 1'b1, 7);
        cyc("r7_full",  1'b0, 0, 32'd0, 0, 7, 1'b0, 1'b0, 1'b1, 7);
        cyc("r7_full2", 1'b0, 0, 32'd0, 0, 7, 1'b0, 1'b0, 1'b1, 7);
        cyc("r7_wb",    1'b1, 7, 32'h7777_0001, 0, 7, 1'b0, 1'b0, 1'b1, 7);
        cyc("r7_still", 1'b0, 0, 32'd0, 0, 0, 1'b0, 1'b0, 1'b1, 7);

        // Simultaneous reserve and write-back on R9 with one pending.
        cyc("r9_rsv",  1'b0, 0, 32'd0, 0, 0, 1'b0, 1'b0, 1'b1, 9);
        cyc("r9_both", 1'b1, 9, 32'h0909_0909, 0, 0, 1'b0, 1'b0, 1'b1, 9);
        cyc("r9_pend", 1'b0, 0, 32'd0, 9, 9, 1'b1, 1'b0, 1'b0, 0);

        // Unreserved write-back sets the sticky error but still commits.
        cyc("r5_wb",   1'b1, 5, 32'h1234_5678, 0, 0, 1'b0, 1'b0, 1'b0, 0);
        cyc("r5_read", 1'b0, 0, 32'd0, 5, 5, 1'b1, 1'b1, 1'b0, 0);

        // Asynchronous reset in mid-cycle with R4 pending twice.
        cyc("r4_wr",   1'b1, 4, 32'h4444_4444, 0, 0, 1'b0, 1'b0, 1'b1, 4);
        cyc("r4_rsv2", 1'b0, 0, 32'd0, 0, 0, 1'b0, 1'b0, 1'b1, 4);
        wb_en = 1'b0; rsv_en = 1'b0;
        rs_addr = 5'd4; rt_addr = 5'd4; rs_used = 1'b1; rt_used = 1'b1;
        #1;
        check_outputs("r4_pre");
        #1;
        reset = 1'b0;
        model_clear();
        #1;
        check_outputs("r4_rst");
        @(negedge clk);
        reset = 1'b1;
        cyc("r4_post", 1'b0, 0, 32'd0, 4, 4, 1'b1, 1'b1, 1'b0, 0);

        // Random traffic; write-backs mostly target pending registers.
        for (int n = 0; n < 400; n++) begin
            int wa;
            bit we;
            pend.delete();
            for (int i = 1; i < NUM; i++) if (m_cnt[i] != 0) pend.push_back(i);
            we = ($urandom_range(0, 99) < 45);
            if (pend.size() != 0 && $urandom_range(0, 9) != 0)
                wa = pend[$urandom_range(0, pend.size() - 1)];
            else
                wa = $urandom_range(0, NUM - 1);
            cyc("rand", we, wa, $urandom(),
                $urandom_range(0, NUM - 1), $urandom_range(0, NUM - 1),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 99) < 40), $urandom_range(0, 15));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_regfile_sb.md
Name: wb_regfile_sb

Overview:
- Register file and hazard scoreboard on the ID side of the pipeline.
- Consumes the write-back triple from the MEM stage (wb_en, wb_addr, wb_data) and commits it to the architectural register array.
- Serves two combinational read ports to ID.
- Keeps a per-register in-flight write counter so that ID stalls on read-after-write hazards, and on load-use hazards, until the producing write-back arrives.

Parameters:
- D_SIZE, 32, register data width in bits
- ADDR_LINE_REG, 5, register address width
- NUM_REG, 32, number of architectural registers (must be <= 2**ADDR_LINE_REG)
- CNT_W, 2, width of each pending-write counter (max in-flight writes per register = 2**CNT_W-1)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- wb_en  in  1  write-back valid from MEM stage
- wb_addr  in  ADDR_LINE_REG  write-back destination register
- wb_data  in  D_SIZE  write-back data
- rs_addr  in  ADDR_LINE_REG  read port A address
- rt_addr  in  ADDR_LINE_REG  read port B address
- rs_used  in  1  ID instruction actually consumes rs
- rt_used  in  1  ID instruction actually consumes rt
- rs_data  out  D_SIZE  read port A data (combinational)
- rt_data  out  D_SIZE  read port B data (combinational)
- rsv_en  in  1  ID issues an instruction that will write rsv_addr
- rsv_addr  in  ADDR_LINE_REG  destination being reserved
- stall  out  1  ID must hold; combinational
- wb_err  out  1  sticky: write-back to a register with no pending reservation

Behaviour:
- Reset (reset=0, async): all registers 0, all counters 0, wb_err 0. rs_data and rt_data then read 0, and stall is 0 when inputs are idle.
- Register 0 is hardwired to zero:
  - reads always return 0;
  - writes are ignored;
  - reservations are ignored;
  - R0 never causes a stall and never sets wb_err.
- Write: on a rising edge with wb_en=1 and wb_addr!=0, reg[wb_addr] <= wb_data. Latency 1 cycle to the array.
- Read: rs_data = reg[rs_addr], and likewise for rt. Bypass rules are under Optional Feature.
- Addresses >= NUM_REG:
  - reads return 0;
  - writes and reservations are dropped;
  - no stall is raised.
- Counter update per register r, each cycle:
  - inc = rsv_en && rsv_addr==r && !stall.
  - dec = wb_en && wb_addr==r && cnt[r]!=0.
  - inc&dec → unchanged; inc only → +1; dec only → -1.
- A reservation accepted while a same-register write-back arrives leaves the count unchanged (net 0).
- wb_err is set (sticky until reset) when wb_en=1, wb_addr!=0, and cnt[wb_addr]==0. The write still commits.
- Hazard for a source operand:
  - src_haz(a, used) = used && a!=0 && eff_cnt(a)!=0.
  - eff_cnt(a) = cnt[a] - (wb_en && wb_addr==a && cnt[a]!=0) when bypass is enabled; otherwise eff_cnt(a) = cnt[a].
- Full condition: full = rsv_en && rsv_addr!=0 && cnt[rsv_addr]==2**CNT_W-1 && !(wb_en && wb_addr==rsv_addr).
- stall = src_haz(rs) || src_haz(rt) || full.
- While stall=1 no reservation is accepted. ID holds rsv_en and the operands until stall=0.
- Stall does not block write-back; write-backs always commit.
- Reset asserted mid-operation clears all counters. Any in-flight write-back after reset then sets wb_err unless the pipeline was also reset; the whole pipeline shares this reset.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - A same-cycle write-back is forwarded. If wb_en && wb_addr==rs_addr && wb_addr!=0, then rs_data = wb_data (same for rt).
  - eff_cnt subtracts the arriving write-back, so the dependent instruction issues in the same cycle the producer writes back.
- Undefined:
  - Reads return the pre-edge array value.
  - eff_cnt = cnt.
  - The dependent instruction stalls one extra cycle and reads the committed value.

Test Plan:
- Reset then read R0..R31 with rs_used=rt_used=1 → all data 0, stall 0, wb_err 0.
- Write R0 = 0xFFFF_FFFF (wb_en=1, no reservation) → R0 still reads 0, wb_err stays 0. Write R5 = 0x1234_5678 with no reservation → R5 reads 0x1234_5678 next cycle, wb_err=1.
- Reserve R3, next cycle rs_addr=3 rs_used=1 → stall=1 until wb_en with wb_addr=3, wb_data=0xA5 arrives:
  - with REGFILE_BYPASS_EN: stall=0 and rs_data=0xA5 in the write-back cycle;
  - without: stall=0 one cycle later, rs_data=0xA5.
- Three back-to-back reservations of R7 (cnt=3), a fourth rsv_en to R7 → stall=1, count stays 3. Assert wb_en to R7 in the same cycle → full clears (count net 3). rt_used=0 with rt_addr=7 → no source stall.
- Same cycle rsv_en R9 and wb_en R9 with cnt[9]=1 → cnt[9] remains 1, no wb_err.
- Reserve R4 twice, assert reset=0 asynchronously mid-cycle → counters 0, stall drops immediately, R4 reads 0.
